// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Word-addressed 32-bit memory slave with programmable wait
//               states. It accepts one read or write from IDLE and completes
//               it with a one-cycle ready pulse. Misaligned, out-of-range and
//               read+write requests complete with fault=1 and leave both the
//               memory and rdata untouched.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        fault
);

    localparam int         DEPTH       = 1 << ADDR_W;
    localparam logic [3:0] C_WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q,   cnt_d;
    logic [ADDR_W-1:0]   idx_q,   idx_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                wr_q,    wr_d;
    logic                bad_q,   bad_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                busy_q,  busy_d;
    logic                fault_q, fault_d;

    logic [31:0]         mem [DEPTH];

    logic                w_req;
    logic                w_bad;
    logic [31:0]         w_mem_rd;
    logic                w_mem_we;

    // Request decode: any bit above the word index, a non-zero byte offset or
    // a simultaneous read+write makes the request illegal.
    always_comb begin
        w_req    = MemRead | MemWrite;
        w_bad    = (addr[1:0] != 2'b00)
                 | ((addr >> (ADDR_W + 2)) != 32'd0)
                 | (MemRead & MemWrite);
        w_mem_rd = mem[idx_q];
        w_mem_we = (state_q == S_RESP) && wr_q && !bad_q && !reset;
    end

    // Next-state and output logic; completion happens on the edge leaving RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        bad_d   = bad_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        busy_d  = busy_q;
        fault_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_req) begin
                    idx_d   = addr[ADDR_W+1:2];
                    wdata_d = wdata;
                    wr_d    = MemWrite;
                    bad_d   = w_bad;
                    busy_d  = 1'b1;
                    cnt_d   = C_WAIT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                // Saturating countdown: the last wait cycle lands on zero.
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                ready_d = 1'b1;
                fault_d = bad_q;
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (!wr_q && !bad_q) begin
                    rdata_d = w_mem_rd;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            wr_q    <= 1'b0;
            bad_q   <= 1'b0;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            bad_q   <= bad_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
        end
    end

    // Memory array; contents survive reset, writes only on a legal completion.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign fault = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Directed, table-driven bench for mem_responder. One instance
//               uses two wait states, a second uses zero wait states for the
//               back-to-back throughput case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    logic        clk;
    logic        reset;

    // Instance with WAIT_CYCLES = 2
    logic        rd2, wr2, ready2, busy2, fault2;
    logic [31:0] addr2, wdata2, rdata2;

    // Instance with WAIT_CYCLES = 0
    logic        rd0, wr0, ready0, busy0, fault0;
    logic [31:0] addr0, wdata0, rdata0;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .MemRead(rd2), .MemWrite(wr2),
        .addr(addr2), .wdata(wdata2), .rdata(rdata2),
        .ready(ready2), .busy(busy2), .fault(fault2)
    );

    mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .MemRead(rd0), .MemWrite(wr0),
        .addr(addr0), .wdata(wdata0), .rdata(rdata0),
        .ready(ready0), .busy(busy0), .fault(fault0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_fault;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request on the 2-wait-state instance; held until ready is seen.
    task automatic do_req(input int id, input vec_t v);
        int n;
        rd2 = v.rd; wr2 = v.wr; addr2 = v.addr; wdata2 = v.wdata;
        tick();
        check($sformatf("v%0d_busy_after_accept", id), {31'd0, busy2}, 32'd1);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ready2) begin
                n = i;
                break;
            end
        end
        rd2 = 1'b0; wr2 = 1'b0;
        check($sformatf("v%0d_latency", id), n, 3);
        check($sformatf("v%0d_busy_at_ready", id), {31'd0, busy2}, 32'd0);
        check($sformatf("v%0d_fault", id), {31'd0, fault2}, {31'd0, v.exp_fault});
        check($sformatf("v%0d_rdata", id), rdata2, v.exp_rdata);
        tick();
        check($sformatf("v%0d_ready_one_cycle", id), {31'd0, ready2}, 32'd0);
    endtask

    initial begin
        int n;
        int pulses;

        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0012, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0001, 1'b1, 32'hDEAD_BEEF};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'h1234_5678};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'h1234_5678};
        vecs[8]  = '{1'b0, 1'b1, 32'h0000_1000, 32'hAAAA_AAAA, 1'b1, 32'h1234_5678};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h1111_1111};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0, 32'h1111_1111};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
        vecs[12] = '{1'b0, 1'b1, 32'h0000_0040, 32'h0BAD_F00D, 1'b0, 32'hCAFE_F00D};
        vecs[13] = '{1'b1, 1'b0, 32'h8000_0040, 32'h0000_0000, 1'b1, 32'hCAFE_F00D};
        vecs[14] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, 1'b0, 32'h0BAD_F00D};

        reset = 1'b1;
        rd2 = 1'b0; wr2 = 1'b0; addr2 = 32'd0; wdata2 = 32'd0;
        rd0 = 1'b0; wr0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state of both instances
        check("rst_ready2", {31'd0, ready2}, 32'd0);
        check("rst_busy2",  {31'd0, busy2},  32'd0);
        check("rst_fault2", {31'd0, fault2}, 32'd0);
        check("rst_rdata2", rdata2, 32'd0);
        check("rst_busy0",  {31'd0, busy0},  32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        tick();

        for (int i = 0; i < 15; i++) begin
            do_req(i, vecs[i]);
        end

        // Write to 0x40 aborted by reset one cycle after accept
        wr2 = 1'b1; addr2 = 32'h0000_0040; wdata2 = 32'h0000_0055;
        tick();
        check("abort_busy_after_accept", {31'd0, busy2}, 32'd1);
        reset = 1'b1;
        wr2 = 1'b0;
        rd2 = 1'b1;     // read of 0x40 held across reset release
        tick();
        check("abort_busy_in_reset",  {31'd0, busy2},  32'd0);
        check("abort_ready_in_reset", {31'd0, ready2}, 32'd0);
        check("abort_rdata_cleared",  rdata2, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("held_req_accepted", {31'd0, busy2}, 32'd1);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ready2) begin
                n = i;
                break;
            end
        end
        rd2 = 1'b0;
        check("held_req_latency", n, 3);
        check("held_req_fault", {31'd0, fault2}, 32'd0);
        check("abort_no_write_rdata", rdata2, 32'h0BAD_F00D);
        tick();

        // Zero-wait instance: one write, then a continuously held read
        wr0 = 1'b1; addr0 = 32'h0000_0008; wdata0 = 32'h600D_CAFE;
        tick();
        check("w0_busy_after_accept", {31'd0, busy0}, 32'd1);
        tick();
        wr0 = 1'b0;
        check("w0_ready", {31'd0, ready0}, 32'd1);
        check("w0_fault", {31'd0, fault0}, 32'd0);
        tick();
        rd0 = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("b2b_busy_%0d", k),  {31'd0, busy0},  {31'd0, ((k % 2) == 1)});
            check($sformatf("b2b_ready_%0d", k), {31'd0, ready0}, {31'd0, ((k % 2) == 0)});
            if (ready0) begin
                pulses++;
                check($sformatf("b2b_rdata_%0d", k), rdata0, 32'h600D_CAFE);
            end
        end
        rd0 = 1'b0;
        check("b2b_pulse_count", pulses, 6);
        tick();
        tick();
        check("b2b_idle_after_release", {31'd0, busy0}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 10, meaning word-index width (memory depth 2^ADDR_W words of 32 bits).
REQ-002 The module SHALL have parameter WAIT_CYCLES, default 2, meaning the number of wait-state cycles inserted before each response (legal range 0-15).
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 The module SHALL have port MemRead, input, 1 bit, read request level from the CPU control unit.
REQ-006 The module SHALL have port MemWrite, input, 1 bit, write request level from the CPU control unit.
REQ-007 The module SHALL have port addr, input, 32 bits, byte address of the access.
REQ-008 The module SHALL have port wdata, input, 32 bits, write data.
REQ-009 The module SHALL have port rdata, output, 32 bits, registered read data.
REQ-010 The module SHALL have port ready, output, 1 bit, one-cycle completion pulse.
REQ-011 The module SHALL have port busy, output, 1 bit, high while a request is in progress.
REQ-012 The module SHALL have port fault, output, 1 bit, error status of the completing request, valid only with ready.

Function
REQ-013 The module SHALL implement the states IDLE, WAIT and RESP.
REQ-014 In IDLE, a rising edge sampling MemRead=1 or MemWrite=1 (accept edge E0) SHALL capture addr, wdata and the operation, set busy=1 and leave IDLE.
REQ-015 Request inputs SHALL be ignored while busy=1; the requester holds them until ready.
REQ-016 ready SHALL be high for exactly one cycle, following edge E0+WAIT_CYCLES+1; with WAIT_CYCLES=0 this is the cycle after E0+1.
REQ-017 The completion edge SHALL clear busy, so busy falls in the same cycle ready rises.
REQ-018 After completion the state SHALL return to IDLE; the next edge may accept a new request, giving back-to-back throughput of one access per WAIT_CYCLES+2 cycles.
REQ-019 Word index SHALL be addr[ADDR_W+1:2].
REQ-020 A request SHALL fault (fault=1 with ready, memory untouched, rdata unchanged) if addr[1:0]!=0, or any bit addr[31:ADDR_W+2] is 1, or MemRead and MemWrite are both 1 at accept.
REQ-021 A faulting request SHALL still observe full WAIT_CYCLES latency.
REQ-022 A legal write SHALL update memory only on the completion edge.
REQ-023 A legal read SHALL load rdata from memory on the completion edge.
REQ-024 rdata SHALL hold its value until the next legal read completes.
REQ-025 A read accepted after a completed write to the same word SHALL return the written data.
REQ-026 The wait counter SHALL be 4 bits and SHALL never wrap; it counts down to zero, then the state moves to RESP.

Reset
REQ-027 reset=1 at a rising edge SHALL force state IDLE, ready=0, busy=0, fault=0, rdata=0 and counter=0, with priority over all other inputs.
REQ-028 Reset during WAIT or RESP SHALL abort the request with no memory write and no ready pulse.
REQ-029 Memory array contents SHALL NOT be cleared by reset.
REQ-030 A request held high across reset deassertion SHALL be accepted on the first non-reset edge.

Verification
REQ-031 The bench SHALL cover: WAIT_CYCLES=2, MemWrite addr=0x10 wdata=0xDEADBEEF, then MemRead addr=0x10 -> each ready 3 cycles after accept; rdata=0xDEADBEEF, fault=0.
REQ-032 The bench SHALL cover: MemRead addr=0x12 -> ready with fault=1, rdata unchanged, memory unchanged.
REQ-033 The bench SHALL cover: MemRead=MemWrite=1 addr=0x20 wdata=0x1 -> fault=1, then a read of 0x20 returns its prior value.
REQ-034 The bench SHALL cover: ADDR_W=10, addr=0x1000 -> fault=1; addr=0xFFC -> legal, last word.
REQ-035 The bench SHALL cover: MemWrite addr=0x40 wdata=0x55 with reset asserted one cycle after accept -> no ready; a subsequent read of 0x40 returns the old value.
REQ-036 The bench SHALL cover: WAIT_CYCLES=0 with continuously held MemRead -> ready every 2nd cycle, busy toggling, and no request lost or duplicated.
